// File: rtl/error_ram_arb_pkg.sv
// error_ram_arb_pkg
// Shared types and defaults for the error_ram arbiter.
//   ADDR_W_DEF / ERR_W_DEF : default address and error-code widths (match error_ram)
//   rd_state_e             : read sequencer states
//   wr_req_t               : one write request (address + error code) at default widths
package error_ram_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int ERR_W_DEF  = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_CAPT  = 2'd2,
      RD_RESP  = 2'd3
   } rd_state_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [ERR_W_DEF-1:0]  err;
   } wr_req_t;

endpackage

// File: rtl/error_ram_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The search for a grant starts at ptr, which points one
// past the last requester that actually transferred.
// Ports:
//   clk, rst  : clock, async active-high reset (ptr returns to 0)
//   req       : request vector
//   advance   : a transfer took place on the current grant this cycle
//   grant     : one-hot grant (combinational), zero when no request
//   ptr       : search start pointer
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] grant_idx;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      found     = 1'b0;
      for (int off = 0; off < N; off++) begin
         idx = PW'((int'(ptr) + off) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/error_ram_arbiter.sv
// error_ram_arbiter
// Front end for error_ram: round-robin shares the RAM write port among NUM_WR
// requesters and runs a single-outstanding read with a response handshake.
// All RAM pins are driven from registers.
// Optional build macro: ERROR_RAM_ARB_STATS_EN adds stat_wr_grants,
// stat_rd_collisions and stat_rd_count.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   wr_valid/wr_ready             : per-requester write handshake
//   wr_addr/wr_err                : per-requester address and error code
//   rd_req_valid/ready/addr       : read request
//   rd_rsp_valid/ready/err        : read response
//   ram_write_*                   : to error_ram write port
//   ram_read_enable/address       : to error_ram read port
//   ram_read_error                : from error_ram, valid one cycle after read_enable
//
// Read sequencer states:
//   state    | meaning
//   IDLE     | ready for a read request
//   RD_ISSUE | RAM samples the registered read request
//   RD_CAPT  | RAM data valid, captured into rd_rsp_err
//   RD_RESP  | response held until rd_rsp_ready
module error_ram_arbiter
   import error_ram_arb_pkg::*;
#(
   parameter int NUM_WR = 4,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ERR_W  = ERR_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_WR-1:0]             wr_valid,
   output logic [NUM_WR-1:0]             wr_ready,
   input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR-1:0][ERR_W-1:0]  wr_err,
   input  logic                          rd_req_valid,
   output logic                          rd_req_ready,
   input  logic [ADDR_W-1:0]             rd_req_addr,
   output logic                          rd_rsp_valid,
   input  logic                          rd_rsp_ready,
   output logic [ERR_W-1:0]              rd_rsp_err,
   output logic                          ram_write_enable,
   output logic [ADDR_W-1:0]             ram_write_address,
   output logic [ERR_W-1:0]              ram_write_error,
   output logic                          ram_read_enable,
   output logic [ADDR_W-1:0]             ram_read_address,
   input  logic [ERR_W-1:0]              ram_read_error
`ifdef ERROR_RAM_ARB_STATS_EN
   ,
   output logic [31:0]                   stat_wr_grants,
   output logic [15:0]                   stat_rd_collisions,
   output logic [15:0]                   stat_rd_count
`endif
);

   localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

   logic [NUM_WR-1:0] grant;
   logic [PW-1:0]     rr_ptr_unused;  // pointer kept inside the arbiter; only exposed for debug
   logic              wr_xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [ERR_W-1:0]  sel_err;
   logic              collision;
   logic              rd_xfer;

   rd_state_e         state, state_nxt;
   logic              rd_en_nxt;
   logic [ADDR_W-1:0] rd_addr_nxt;
   logic              rsp_valid_nxt;
   logic [ERR_W-1:0]  rsp_err_nxt;

   rr_arbiter #(.N(NUM_WR)) u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (wr_valid),
      .advance (wr_xfer),
      .grant   (grant),
      .ptr     (rr_ptr_unused)
   );

   // Grant only goes to a valid requester, so any ready bit is a transfer.
   assign wr_ready = rst ? '0 : grant;
   assign wr_xfer  = |wr_ready;

   always_comb begin
      sel_addr = '0;
      sel_err  = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (grant[i]) begin
            sel_addr = wr_addr[i];
            sel_err  = wr_err[i];
         end
      end
   end

   // Accepting a read in the same cycle as a write to that address would have
   // the RAM see both on the same edge; hold the read off one cycle instead.
   assign collision    = (state == IDLE) && wr_xfer && (sel_addr == rd_req_addr);
   assign rd_req_ready = !rst && (state == IDLE) && !collision;
   assign rd_xfer      = rd_req_valid && rd_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_write_enable  <= 1'b0;
         ram_write_address <= '0;
         ram_write_error   <= '0;
      end else begin
         ram_write_enable <= wr_xfer;
         if (wr_xfer) begin
            ram_write_address <= sel_addr;
            ram_write_error   <= sel_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         ram_read_enable  <= 1'b0;
         ram_read_address <= '0;
         rd_rsp_valid     <= 1'b0;
         rd_rsp_err       <= '0;
      end else begin
         state            <= state_nxt;
         ram_read_enable  <= rd_en_nxt;
         ram_read_address <= rd_addr_nxt;
         rd_rsp_valid     <= rsp_valid_nxt;
         rd_rsp_err       <= rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      rd_en_nxt     = 1'b0;
      rd_addr_nxt   = ram_read_address;
      rsp_valid_nxt = rd_rsp_valid;
      rsp_err_nxt   = rd_rsp_err;
      case (state)
         IDLE: begin
            if (rd_xfer) begin
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = rd_req_addr;
               state_nxt   = RD_ISSUE;
            end
         end
         RD_ISSUE: state_nxt = RD_CAPT;
         RD_CAPT: begin
            rsp_err_nxt   = ram_read_error;
            rsp_valid_nxt = 1'b1;
            state_nxt     = RD_RESP;
         end
         RD_RESP: begin
            if (rd_rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ERROR_RAM_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_wr_grants     <= '0;
         stat_rd_collisions <= '0;
         stat_rd_count      <= '0;
      end else begin
         if (wr_xfer) begin
            stat_wr_grants <= stat_wr_grants + 32'd1;
         end
         if (collision && rd_req_valid && (stat_rd_collisions != 16'hFFFF)) begin
            stat_rd_collisions <= stat_rd_collisions + 16'd1;
         end
         if ((state == RD_RESP) && rd_rsp_ready) begin
            stat_rd_count <= stat_rd_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_error_ram_arbiter.sv
module tb_error_ram_arbiter;

   localparam int NW = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NW-1:0]         wr_valid = '0;
   logic [NW-1:0]         wr_ready;
   logic [NW-1:0][31:0]   wr_addr = '0;
   logic [NW-1:0][9:0]    wr_err = '0;
   logic                  rd_req_valid = 1'b0;
   logic                  rd_req_ready;
   logic [31:0]           rd_req_addr = '0;
   logic                  rd_rsp_valid;
   logic                  rd_rsp_ready = 1'b0;
   logic [9:0]            rd_rsp_err;
   logic                  ram_write_enable;
   logic [31:0]           ram_write_address;
   logic [9:0]            ram_write_error;
   logic                  ram_read_enable;
   logic [31:0]           ram_read_address;
   logic [9:0]            ram_read_error = '0;
`ifdef ERROR_RAM_ARB_STATS_EN
   logic [31:0]           stat_wr_grants;
   logic [15:0]           stat_rd_collisions;
   logic [15:0]           stat_rd_count;
`endif

   error_ram_arbiter #(.NUM_WR(NW), .ADDR_W(32), .ERR_W(10)) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_valid          (wr_valid),
      .wr_ready          (wr_ready),
      .wr_addr           (wr_addr),
      .wr_err            (wr_err),
      .rd_req_valid      (rd_req_valid),
      .rd_req_ready      (rd_req_ready),
      .rd_req_addr       (rd_req_addr),
      .rd_rsp_valid      (rd_rsp_valid),
      .rd_rsp_ready      (rd_rsp_ready),
      .rd_rsp_err        (rd_rsp_err),
      .ram_write_enable  (ram_write_enable),
      .ram_write_address (ram_write_address),
      .ram_write_error   (ram_write_error),
      .ram_read_enable   (ram_read_enable),
      .ram_read_address  (ram_read_address),
      .ram_read_error    (ram_read_error)
`ifdef ERROR_RAM_ARB_STATS_EN
      ,
      .stat_wr_grants     (stat_wr_grants),
      .stat_rd_collisions (stat_rd_collisions),
      .stat_rd_count      (stat_rd_count)
`endif
   );

   always #5 clk = ~clk;

   // error_ram stand-in: read data registered one cycle after read_enable,
   // read sees the contents from before a same-edge write.
   logic [9:0] mem [logic [31:0]];
   always @(posedge clk) begin
      if (ram_read_enable)
         ram_read_error <= mem.exists(ram_read_address) ? mem[ram_read_address] : 10'h0;
      if (ram_write_enable)
         mem[ram_write_address] = ram_write_error;
   end

   // ---------------- reference model state ----------------
   int          passed = 0;
   int          total  = 0;
   int          fails  = 0;
   logic [9:0]  gold [logic [31:0]];   // what the RAM holds once every accepted write lands
   int          ptr;                   // next requester to search from
   bit          out;                   // a read is outstanding
   int          age;                   // edges since that read was accepted
   logic [9:0]  snap;                  // data the outstanding read must return
   logic        e_we, e_ren, e_vld;
   logic [31:0] e_wa, e_raddr;
   logic [9:0]  e_wd, e_err;
   logic        obs_rdy;
   int          glog[$];               // observed granted requesters

   function automatic logic [9:0] gold_rd(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : 10'h0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ptr = 0; out = 0; age = 0; snap = '0;
      e_we = 0; e_wa = '0; e_wd = '0;
      e_ren = 0; e_raddr = '0; e_vld = 0; e_err = '0;
   endtask

   // One clock: inputs are already driven (at a negedge) by the caller.
   task automatic step();
      int          gi;
      logic [NW-1:0] exp_g;
      logic        exp_rdy, acc, hs;
      logic [31:0] ga, ra;
      logic [9:0]  gd;
      #1;
      gi = -1;
      for (int k = 0; k < NW; k++) begin
         int j = (ptr + k) % NW;
         if (gi < 0 && wr_valid[j]) gi = j;
      end
      exp_g = (gi >= 0) ? NW'(1 << gi) : '0;
      chk("wr_ready", wr_ready, exp_g);
      ga = (gi >= 0) ? wr_addr[gi] : '0;
      gd = (gi >= 0) ? wr_err[gi] : '0;
      exp_rdy = !out && !(gi >= 0 && ga == rd_req_addr);
      chk("rd_req_ready", rd_req_ready, exp_rdy);
      obs_rdy = rd_req_ready;
      for (int k = 0; k < NW; k++) if (wr_ready[k]) glog.push_back(k);
      acc = rd_req_valid && exp_rdy;
      hs  = e_vld && rd_rsp_ready;
      ra  = rd_req_addr;
      @(posedge clk);
      if (hs) begin
         out = 0; e_vld = 0;
      end else if (out) begin
         age++;
         if (age == 2) begin e_vld = 1; e_err = snap; end
      end
      if (acc) begin
         out = 1; age = 0; snap = gold_rd(ra); e_ren = 1; e_raddr = ra;
      end else begin
         e_ren = 0;
      end
      if (gi >= 0) begin
         ptr = (gi + 1) % NW; gold[ga] = gd; e_we = 1; e_wa = ga; e_wd = gd;
      end else begin
         e_we = 0;
      end
      @(negedge clk);
      chk("ram_write_enable", ram_write_enable, e_we);
      chk("ram_write_address", ram_write_address, e_wa);
      chk("ram_write_error", ram_write_error, e_wd);
      chk("ram_read_enable", ram_read_enable, e_ren);
      chk("ram_read_address", ram_read_address, e_raddr);
      chk("rd_rsp_valid", rd_rsp_valid, e_vld);
      chk("rd_rsp_err", rd_rsp_err, e_err);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rd_rsp_valid && n < 8) begin step(); n++; end
   endtask

   task automatic reset_checks();
      #1;
      chk("rst wr_ready", wr_ready, '0);
      chk("rst rd_req_ready", rd_req_ready, 0);
      chk("rst rd_rsp_valid", rd_rsp_valid, 0);
      chk("rst rd_rsp_err", rd_rsp_err, 0);
      chk("rst ram_write_enable", ram_write_enable, 0);
      chk("rst ram_write_address", ram_write_address, 0);
      chk("rst ram_write_error", ram_write_error, 0);
      chk("rst ram_read_enable", ram_read_enable, 0);
      chk("rst ram_read_address", ram_read_address, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      reset_checks();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      glog.delete();
   endtask

   task automatic finish_read();
      int n = 0;
      rd_rsp_ready = 1'b1;
      while (out && n < 8) begin step(); n++; end
      chk("read drained", out, 0);
      rd_rsp_ready = 1'b0;
   endtask

   logic [31:0] pool [4] = '{32'hAABBCCDD, 32'h12345678, 32'h87654321, 32'h00000040};
   int          fair_a [5] = '{0, 1, 2, 3, 0};
   int          fair_b [6] = '{1, 3, 0, 1, 3, 0};

   initial begin
      int n;
      model_reset();
      @(negedge clk);
      wr_valid = '1;
      @(negedge clk);
      reset_checks();
      wr_valid = '0;
      rst = 1'b0;

      // single write then read
      wr_valid = 4'b0001; wr_addr[0] = 32'hAABBCCDD; wr_err[0] = 10'b1010101010;
      step();
      wr_valid = '0;
      step();
      rd_req_valid = 1'b1; rd_req_addr = 32'hAABBCCDD;
      step();
      chk("single accept", obs_rdy, 1);
      rd_req_valid = 1'b0;
      wait_rsp(n);
      chk("single latency", n, 2);
      chk("single rsp", rd_rsp_err, 10'b1010101010);
      finish_read();

      // fairness from reset release
      for (int i = 0; i < NW; i++) begin wr_addr[i] = 32'h100 + i; wr_err[i] = 10'(i + 1); end
      wr_valid = '1;
      do_reset();
      repeat (5) step();
      chk("fair_a size", glog.size(), 5);
      for (int i = 0; i < 5; i++) chk("fair_a seq", glog[i], fair_a[i]);
      glog.delete();
      wr_valid = 4'b1011;
      repeat (6) step();
      chk("fair_b size", glog.size(), 6);
      for (int i = 0; i < 6; i++) chk("fair_b seq", glog[i], fair_b[i]);
      wr_valid = '0;

      // collision
      wr_valid = 4'b0010; wr_addr[1] = 32'h12345678; wr_err[1] = 10'b1110001110;
      rd_req_valid = 1'b1; rd_req_addr = 32'h12345678;
      step();
      chk("coll blocked", obs_rdy, 0);
      wr_valid = '0;
      step();
      chk("coll accepted", obs_rdy, 1);
      rd_req_valid = 1'b0;
      wait_rsp(n);
      chk("coll latency", n, 2);
      chk("coll rsp", rd_rsp_err, 10'b1110001110);
`ifdef ERROR_RAM_ARB_STATS_EN
      chk("stat collisions", stat_rd_collisions, 1);
`endif
      finish_read();

      // backpressure
      wr_valid = 4'b1000; wr_addr[3] = 32'h87654321; wr_err[3] = 10'b0001110001;
      step();
      wr_valid = '0;
      rd_req_valid = 1'b1; rd_req_addr = 32'hAABBCCDD;
      step();
      rd_req_addr = 32'h87654321;
      wait_rsp(n);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp rsp_valid", rd_rsp_valid, 1);
         chk("bp rsp_err", rd_rsp_err, 10'b1010101010);
         chk("bp req_ready", obs_rdy, 0);
      end
      rd_rsp_ready = 1'b1;
      step();
      chk("bp hs req_ready", obs_rdy, 0);
      rd_rsp_ready = 1'b0;
      step();
      chk("bp second accept", obs_rdy, 1);
      rd_req_valid = 1'b0;
      wait_rsp(n);
      chk("bp second rsp", rd_rsp_err, 10'b0001110001);
      finish_read();

      // unwritten address
      rd_req_valid = 1'b1; rd_req_addr = 32'hDEADBEEF;
      step();
      rd_req_valid = 1'b0;
      wait_rsp(n);
      chk("unwritten rsp", rd_rsp_err, 10'h000);
      finish_read();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         wr_valid = NW'($urandom);
         for (int i = 0; i < NW; i++) begin
            wr_addr[i] = pool[$urandom_range(0, 3)];
            wr_err[i]  = 10'($urandom);
         end
         rd_req_valid = ($urandom_range(0, 1) == 1);
         rd_req_addr  = pool[$urandom_range(0, 3)];
         rd_rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      wr_valid = '0; rd_req_valid = 1'b0;
      finish_read();
      step();

      // reset while the read sits in RD_CAPT
      rd_req_valid = 1'b1; rd_req_addr = pool[0];
      step();
      chk("rcapt accept", obs_rdy, 1);
      rd_req_valid = 1'b0;
      step();
      wr_valid = '1;
      do_reset();
      step();
      chk("post-reset first grant", glog[0], 0);
      wr_valid = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post-reset no rsp", rd_rsp_valid, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/error_ram_arbiter.md
# error_ram_arbiter

Sequencer and arbiter in front of `error_ram`. It shares the RAM's write port round-robin among `NUM_WR` error-reporting requesters, and runs a single-outstanding read transaction for one reader with a response handshake. It drives the RAM port pins from registers and prevents same-cycle write/read collisions on the same address.

## Interface
- `NUM_WR`, 4: number of write requesters (2..8).
- `ADDR_W`, 32: error-tag address width; matches `error_ram`.
- `ERR_W`, 10: error code width; matches `error_ram`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_valid` in NUM_WR: per-requester write request.
- `wr_ready` out NUM_WR: per-requester accept. Combinational from the grant; at most one bit set.
- `wr_addr` in NUM_WR×ADDR_W: per-requester address.
- `wr_err` in NUM_WR×ERR_W: per-requester error code.
- `rd_req_valid` in 1: read request.
- `rd_req_ready` out 1: read accept.
- `rd_req_addr` in ADDR_W: read address.
- `rd_rsp_valid` out 1: read response valid.
- `rd_rsp_ready` in 1: response consumed.
- `rd_rsp_err` out ERR_W: read data.
- `ram_write_enable` out 1: to `error_ram.write_enable`.
- `ram_write_address` out ADDR_W: to `error_ram.write_address`.
- `ram_write_error` out ERR_W: to `error_ram.write_error`.
- `ram_read_enable` out 1: to `error_ram.read_enable`.
- `ram_read_address` out ADDR_W: to `error_ram.read_address`.
- `ram_read_error` in ERR_W: from `error_ram.read_error`. Valid the cycle after `ram_read_enable` is sampled.

## Operation
- **Write arbitration:** round-robin over requesters with `wr_valid` set. Search starts at the requester after the last granted one; after reset the pointer is 0, so requester 0 has highest priority.
  - At most one grant per cycle.
  - A transfer occurs when `wr_valid[i] & wr_ready[i]`.
  - The pointer advances only on a transfer.
- **Write issue:** on a transfer, `ram_write_enable`, `ram_write_address` and `ram_write_error` are registered for exactly one cycle. Otherwise `ram_write_enable` is 0 and address/data hold their last values.
- **Read FSM states:**
  - `IDLE`: `rd_req_ready` = 1 unless blocked by a collision. On a read transfer, register `ram_read_enable` = 1 and `ram_read_address`, then go to `RD_ISSUE`.
  - `RD_ISSUE`: the RAM samples the request this cycle. Deassert `ram_read_enable`, go to `RD_CAPT`.
  - `RD_CAPT`: register `rd_rsp_err` ← `ram_read_error` and set `rd_rsp_valid` = 1, go to `RD_RESP`.
  - `RD_RESP`: hold `rd_rsp_valid` and `rd_rsp_err` stable until `rd_rsp_ready`. On handshake clear `rd_rsp_valid` and go to `IDLE`.
- `rd_req_ready` = 0 in every state other than `IDLE`.
- **Collision:** if in `IDLE` the read address equals the address of the write being granted this cycle, `rd_req_ready` = 0 for that cycle. The read is accepted on a later cycle and returns the newly written error.
- Writes proceed in every read state; the read path never stalls writes.
- An unwritten address returns whatever `error_ram` yields (0 after reset). The arbiter does not interpret it.

## Timing
- **Reset values:**
  - `wr_ready` = 0, `rd_req_ready` = 0 during `rst`.
  - `rd_rsp_valid` = 0, `rd_rsp_err` = 0.
  - All `ram_*` outputs = 0.
  - FSM = `IDLE`, RR pointer = 0.
- **Write latency:** transfer at edge E0 → `ram_write_enable` high E0..E1 → RAM updated at E1.
- **Read latency:** request transfer at E0 → `rd_rsp_valid` high after E2, i.e. 2 cycles. Throughput is at most one read per 4 cycles (accept at E0, response handshake no earlier than E3, next accept no earlier than E4).
- A write granted at E-1 and a read of the same address accepted at E0 returns the new data; no stall is required.
- **Reset mid-operation:** any outstanding read is dropped with no response; a pending write not yet registered is lost.

## Configuration
- `ERROR_RAM_ARB_STATS_EN` defined adds three outputs:
  - `stat_wr_grants` (32 bit, wrapping): count of write transfers.
  - `stat_rd_collisions` (16 bit, saturating at 0xFFFF): cycles a read was blocked by a collision.
  - `stat_rd_count` (16 bit, wrapping): completed read responses.
  - All three reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `error_ram_arb_pkg`:
  - `ADDR_W` and `ERR_W` defaults.
  - `rd_state_e` enum (`IDLE`, `RD_ISSUE`, `RD_CAPT`, `RD_RESP`).
  - `wr_req_t` struct (`addr`, `err`).
- Sub-module `rr_arbiter` (params `N`): inputs are the request vector and an advance strobe; outputs are a one-hot grant and the pointer register. It is instantiated once for the write path.

## Test plan
- **Single write and read:** requester 0 writes 0xAABBCCDD / 10'b1010101010 → `ram_write_enable` pulses 1 cycle after accept. Read of 0xAABBCCDD → `rd_rsp_valid` 2 cycles after accept with `rd_rsp_err` = 10'b1010101010.
- **Fairness:** all 4 `wr_valid` held high from reset release → grants 0, 1, 2, 3, 0 on consecutive cycles. Drop requester 2 → sequence becomes 0, 1, 3.
- **Collision:** requester 1 is granted 0x12345678 / 10'b1110001110 in the same cycle as a read of 0x12345678 → `rd_req_ready` = 0 that cycle, read accepted next cycle, response = 10'b1110001110. With stats enabled, `stat_rd_collisions` = 1.
- **Backpressure:** `rd_rsp_ready` held low 5 cycles → `rd_rsp_valid` and `rd_rsp_err` stable and `rd_req_ready` = 0 throughout. A second read (0x87654321 → 10'b0001110001) is accepted the cycle after the handshake.
- **Unwritten address:** read of 0xDEADBEEF → `rd_rsp_err` = 10'b0000000000.
- **Reset in `RD_CAPT`:** all outputs go to 0 immediately on `rst`. No `rd_rsp_valid` appears after release, and the first grant goes to requester 0.
